// File: rtl/fetch_queue_if.sv
// Fetch queue bus: instruction-memory handshake, redirect/stall control
// from decode, and the head-of-queue instruction presented to decode.
interface fetch_queue_if;
  logic        mem_req;
  logic [15:0] mem_addr;
  logic        mem_ack;
  logic [15:0] mem_rdata;
  logic        redirect;
  logic [15:0] redirect_pc;
  logic        stall;
  logic        inst_valid;
  logic [15:0] inst;
  logic [15:0] inst_pc_plus2;
  logic [4:0]  count;

  // The fetch queue itself
  modport master (
    output mem_req, mem_addr, inst_valid, inst, inst_pc_plus2, count,
    input  mem_ack, mem_rdata, redirect, redirect_pc, stall
  );

  // Memory and decode stage surrounding the queue
  modport slave (
    input  mem_req, mem_addr, inst_valid, inst, inst_pc_plus2, count,
    output mem_ack, mem_rdata, redirect, redirect_pc, stall
  );
endinterface

// File: rtl/fetch_queue.sv
// Instruction fetch queue: issues one memory read at a time, buffers the
// returned words with their address+2 in a circular buffer and hands them
// to decode. A redirect flushes the buffer and restarts fetching; a read
// still in flight at redirect time is waited out in DISCARD and dropped.
// DEPTH must be a power of two between 2 and 16 so the pointers wrap
// naturally and the count fits in 5 bits.
module fetch_queue #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input logic          clk,
  input logic          reset_n,
  fetch_queue_if.master bus
);

  localparam int unsigned PTR_W     = $clog2(DEPTH);
  localparam logic [4:0]  DEPTH_CNT = 5'(DEPTH);

  typedef enum logic [1:0] {IDLE, REQ, DISCARD} state_t;

  state_t             state;
  logic [15:0]        fetch_pc;
  logic [15:0]        req_addr;
  logic               req_q;
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [4:0]         count_q;
  logic [31:0]        entries [DEPTH];
  logic [31:0]        head;
  logic               push;
  logic               pop;
  logic               room_after_push;
  logic               inst_valid;
  logic [15:0]        next_pc;

  assign inst_valid      = (count_q != 5'd0);
  assign pop             = inst_valid && !bus.stall && !bus.redirect;
  assign push            = (state == REQ) && bus.mem_ack && !bus.redirect;
  assign next_pc         = fetch_pc + 16'd2;
  assign room_after_push = (count_q + 5'd1 - {4'd0, pop}) < DEPTH_CNT;

  // Request FSM: tracks the single outstanding read, the fetch PC and the
  // registered request address (which diverges from the fetch PC only
  // while an abandoned read is drained in DISCARD)
  always_ff @(posedge clk or posedge reset_n) begin
    if (reset_n) begin
      state    <= IDLE;
      fetch_pc <= RESET_PC;
      req_addr <= RESET_PC;
      req_q    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.redirect) begin
            fetch_pc <= bus.redirect_pc;
            req_addr <= bus.redirect_pc;
            state    <= REQ;
            req_q    <= 1'b1;
          end else if (count_q < DEPTH_CNT) begin
            state <= REQ;
            req_q <= 1'b1;
          end
        end
        REQ: begin
          if (bus.redirect) begin
            fetch_pc <= bus.redirect_pc;
            if (bus.mem_ack) begin
              req_addr <= bus.redirect_pc;
            end else begin
              state <= DISCARD;
            end
          end else if (bus.mem_ack) begin
            fetch_pc <= next_pc;
            req_addr <= next_pc;
            if (!room_after_push) begin
              state <= IDLE;
              req_q <= 1'b0;
            end
          end
        end
        DISCARD: begin
          if (bus.redirect) begin
            fetch_pc <= bus.redirect_pc;
          end else if (bus.mem_ack) begin
            state    <= REQ;
            req_addr <= fetch_pc;
          end
        end
        default: begin
          state <= IDLE;
          req_q <= 1'b0;
        end
      endcase
    end
  end

  // Queue bookkeeping: pointers and occupancy, cleared by redirect
  always_ff @(posedge clk or posedge reset_n) begin
    if (reset_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= 5'd0;
    end else if (bus.redirect) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= 5'd0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count_q <= count_q + 5'd1;
        2'b01:   count_q <= count_q - 5'd1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Entry storage: word in the upper half, its address+2 in the lower half
  always_ff @(posedge clk) begin
    if (push) begin
      entries[wr_ptr] <= {bus.mem_rdata, req_addr + 16'd2};
    end
  end

  assign head              = entries[rd_ptr];
  assign bus.inst_valid    = inst_valid;
  assign bus.inst          = inst_valid ? head[31:16] : 16'h0000;
  assign bus.inst_pc_plus2 = inst_valid ? head[15:0]  : 16'h0000;
  assign bus.count         = count_q;
  assign bus.mem_req       = req_q;
  assign bus.mem_addr      = req_addr;

endmodule

// File: doc/fetch_queue.md
FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 Parameter DEPTH, default 4, queue entries; SHALL be a power of two, 2..16.
REQ-002 Parameter RESET_PC, default 16'h0000, first fetch address after reset.
REQ-003 clk  input  1  single clock; all state SHALL update on the rising edge.
REQ-004 reset_n  input  1  asynchronous, active-high reset: asserted at 1, despite the name.
REQ-005 mem_req  output  1  instruction-memory read request.
REQ-006 mem_addr  output  16  byte address of the request.
REQ-007 mem_ack  input  1  memory accepts the request and returns data this cycle.
REQ-008 mem_rdata  input  16  instruction word; valid only when mem_ack=1.
REQ-009 redirect  input  1  taken branch or jump from ID; flush and refetch.
REQ-010 redirect_pc  input  16  new fetch address; valid only when redirect=1.
REQ-011 stall  input  1  IF/ID buffer not accepting this cycle.
REQ-012 inst_valid  output  1  head entry present.
REQ-013 inst  output  16  head instruction word.
REQ-014 inst_pc_plus2  output  16  head instruction address + 2.
REQ-015 count  output  5  number of occupied entries.

Function
REQ-016 Storage SHALL be a circular buffer of DEPTH entries; each entry holds {word, address+2}; read/write pointers SHALL wrap modulo DEPTH.
REQ-017 inst_valid SHALL equal (count != 0); inst and inst_pc_plus2 SHALL be driven combinationally from the head entry.
REQ-018 Pop SHALL occur on an edge where inst_valid=1, stall=0 and redirect=0.
REQ-019 Push SHALL occur on an edge where the FSM is in REQ, mem_ack=1 and redirect=0; the stored address+2 SHALL be mem_addr+2 modulo 2^16, so 16'hFFFE yields 16'h0000.
REQ-020 A simultaneous push and pop SHALL leave count unchanged.
REQ-021 The FSM SHALL have three states: IDLE, REQ and DISCARD.
REQ-022 mem_req SHALL be 1 in REQ and in DISCARD, and 0 in IDLE.
REQ-023 While mem_req=1 and mem_ack=0, mem_addr SHALL stay stable. Only one request SHALL be outstanding at a time.
REQ-024 IDLE -> REQ on the next edge when count < DEPTH. Otherwise the FSM SHALL remain in IDLE.
REQ-025 In REQ, with mem_ack=1 and no redirect, the fetch PC SHALL advance by 2.
REQ-026 After the REQ push in REQ-025, the FSM SHALL stay in REQ if (count + 1 - pop) < DEPTH, and go to IDLE otherwise. This gives one fetch per cycle while the queue has space.
REQ-027 redirect=1 has priority over push and pop. On that edge the queue SHALL empty (count=0, pointers reset) and the fetch PC SHALL load redirect_pc.
REQ-028 redirect in REQ with mem_ack=0 -> DISCARD: mem_req and mem_addr SHALL hold the old request until it is acknowledged.
REQ-029 redirect in REQ with mem_ack=1 -> the returned word SHALL be dropped and the FSM SHALL stay in REQ with mem_addr=redirect_pc on the next cycle.
REQ-030 redirect in IDLE -> REQ with mem_addr=redirect_pc on the next cycle.
REQ-031 In DISCARD, mem_ack=1 -> the word SHALL be dropped and the FSM SHALL go to REQ at the fetch PC.
REQ-032 redirect in DISCARD SHALL update the fetch PC and keep the FSM in DISCARD.
REQ-033 inst and inst_pc_plus2 SHALL remain stable while stall=1 and no redirect occurs.

Reset
REQ-034 While reset_n=1, the block SHALL force: state IDLE, fetch PC = RESET_PC, count=0, pointers 0, mem_req=0, inst_valid=0.
REQ-035 mem_addr SHALL equal the fetch PC; inst and inst_pc_plus2 SHALL be 16'h0000 while count=0.
REQ-036 Assertion mid-request SHALL abandon the outstanding request without waiting for mem_ack. Storage contents need not be cleared.
REQ-037 The first mem_req SHALL assert one clock edge after reset_n deasserts, with mem_addr=RESET_PC.

Verification
REQ-038 Reset release, mem_ack tied 1, stall=0 -> mem_addr 0000,0002,0004 on consecutive cycles; inst_valid=1 from the third cycle; inst_pc_plus2 follows 0002,0004,...
REQ-039 DEPTH=4, stall=1, mem_ack=1 -> count reaches 4 and mem_req drops to 0 in the same cycle. Then stall=0 for one cycle -> count 3, mem_req=1 next cycle.
REQ-040 mem_ack held 0 for 3 cycles, redirect to 0x0100 in the first of them -> mem_addr holds the old value until ack; the acknowledged word is never visible; next mem_addr=0x0100; count=0 throughout.
REQ-041 redirect=1 to 0x0040 on the same edge as mem_ack=1 and a pop-eligible head -> count=0, the word is dropped, and mem_addr=0x0040 next cycle.
REQ-042 RESET_PC=16'hFFFE, mem_ack=1 -> first entry inst_pc_plus2=0000; second mem_addr=0000.
REQ-043 reset_n pulsed while count=3 and a request is pending -> inst_valid=0 and mem_req=0 immediately (asynchronous); after release, the fetch restarts at RESET_PC.
